// File: rtl/pifo_pkg.sv
// Shared definitions for the SRAM-based PIFO tree.
//   - slot / entry width helpers (slot = {size, meta, prio})
//   - per-slot field offset helpers
//   - EMPTY_SLOT / EMPTY_ENTRY generators (prio all-ones, meta/size zero)
//   - level storage FSM encodings
// Reused by the PIFO node and by every level storage wrapper.
package pifo_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } lvl_state_e;

  // Upper bound on entry width handled by the constant generators below.
  localparam int MAX_EW = 512;

  localparam int PTW_DEF = 16;
  localparam int MTW_DEF = 32;
  localparam int CTW_DEF = 10;

  function automatic int slot_w(input int ptw, input int mtw, input int ctw);
    return ptw + mtw + ctw;
  endfunction

  function automatic int entry_w(input int ptw, input int mtw, input int ctw);
    return 2 * slot_w(ptw, mtw, ctw);
  endfunction

  // Field offsets inside an entry; slot 0 occupies the low half.
  function automatic int prio_off(input int slot, input int ptw, input int mtw, input int ctw);
    return slot * slot_w(ptw, mtw, ctw);
  endfunction

  function automatic int meta_off(input int slot, input int ptw, input int mtw, input int ctw);
    return prio_off(slot, ptw, mtw, ctw) + ptw;
  endfunction

  function automatic int size_off(input int slot, input int ptw, input int mtw, input int ctw);
    return prio_off(slot, ptw, mtw, ctw) + ptw + mtw;
  endfunction

  function automatic logic [MAX_EW-1:0] empty_slot(input int ptw, input int mtw, input int ctw);
    logic [MAX_EW-1:0] s;
    s = '0;
    for (int i = 0; i < ptw; i++) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [MAX_EW-1:0] empty_entry(input int ptw, input int mtw, input int ctw);
    logic [MAX_EW-1:0] s;
    s = empty_slot(ptw, mtw, ctw);
    return s | (s << slot_w(ptw, mtw, ctw));
  endfunction

endpackage

// File: rtl/pifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old
// contents (read-first); the wrapper handles write-first forwarding.
// Ports:
//   i_clk            clock
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr           read enable / address
//   o_rdata          registered read data, holds until the next i_re
module pifo_sdp_ram #(
  parameter int W     = 116,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    if (i_re) rdata_q <= mem[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/pifo_level_sram.sv
// Storage responder for one PIFO tree level.
// After reset it writes EMPTY_ENTRY to every address (DEPTH cycles), then
// serves one read + one write per cycle. Reads have one-cycle latency,
// are write-first on same-address collision, and the result is held until
// the next accepted read. Out-of-range accesses read EMPTY_ENTRY, drop
// writes and set a sticky o_oob flag.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_read, i_read_addr     read request
//   o_read_data             held read data
//   i_write, i_write_addr, i_write_data   write request
//   o_init_done             high once initialisation has finished
//   o_oob                   sticky out-of-range access flag
module pifo_level_sram
  import pifo_pkg::*;
#(
  parameter int PTW   = 16,
  parameter int MTW   = 32,
  parameter int CTW   = 10,
  parameter int ADW   = 20,
  parameter int DEPTH = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_read,
  input  logic [ADW-1:0]               i_read_addr,
  output logic [2*(CTW+MTW+PTW)-1:0]   o_read_data,
  input  logic                         i_write,
  input  logic [ADW-1:0]               i_write_addr,
  input  logic [2*(CTW+MTW+PTW)-1:0]   i_write_data,
  output logic                         o_init_done,
  output logic                         o_oob
);

  localparam int EW    = entry_w(PTW, MTW, CTW);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW;  // enough to hold DEPTH-1; the counter stops there
  localparam logic [EW-1:0]    EMPTY_ENTRY = EW'(empty_entry(PTW, MTW, CTW));
  localparam logic [ADW:0]     DEPTH_X     = (ADW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEPTH - 1);

  lvl_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             oob_q, oob_d;
  logic [EW-1:0]    hold_q, hold_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_fwd_q, rd_fwd_d;
  logic             rd_oob_q, rd_oob_d;
  logic [EW-1:0]    fwd_data_q, fwd_data_d;

  logic             ram_we, ram_re;
  logic [AW-1:0]    ram_waddr, ram_raddr;
  logic [EW-1:0]    ram_wdata, ram_rdata;
  logic             rd_oob, wr_oob;
  logic [EW-1:0]    rd_data;

  assign rd_oob = {1'b0, i_read_addr}  >= DEPTH_X;
  assign wr_oob = {1'b0, i_write_addr} >= DEPTH_X;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    oob_d      = oob_q;
    rd_pend_d  = 1'b0;
    rd_fwd_d   = 1'b0;
    rd_oob_d   = 1'b0;
    fwd_data_d = fwd_data_q;
    ram_we     = 1'b0;
    ram_waddr  = AW'(cnt_q);
    ram_wdata  = EMPTY_ENTRY;
    ram_re     = 1'b0;
    ram_raddr  = i_read_addr[AW-1:0];

    // The cycle after an accepted read the fresh value comes from the RAM
    // (or the forward / empty override); otherwise the hold register.
    if (rd_pend_q) begin
      if (rd_oob_q)      rd_data = EMPTY_ENTRY;
      else if (rd_fwd_q) rd_data = fwd_data_q;
      else               rd_data = ram_rdata;
    end else begin
      rd_data = hold_q;
    end
    hold_d = rd_data;

    case (state_q)
      ST_INIT: begin
        // Init writer owns the RAM write port; user traffic is ignored.
        ram_we = 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_READY;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: begin
        ram_we    = i_write & ~wr_oob;
        ram_waddr = i_write_addr[AW-1:0];
        ram_wdata = i_write_data;
        if (i_read) begin
          rd_pend_d = 1'b1;
          rd_oob_d  = rd_oob;
          ram_re    = ~rd_oob;
          // RAM is read-first, so same-address writes are forwarded here.
          if (i_write && !wr_oob && i_write_addr == i_read_addr) begin
            rd_fwd_d   = 1'b1;
            fwd_data_d = i_write_data;
          end
        end
        if ((i_read && rd_oob) || (i_write && wr_oob)) oob_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      oob_q      <= 1'b0;
      hold_q     <= EMPTY_ENTRY;
      rd_pend_q  <= 1'b0;
      rd_fwd_q   <= 1'b0;
      rd_oob_q   <= 1'b0;
      fwd_data_q <= EMPTY_ENTRY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      oob_q      <= oob_d;
      hold_q     <= hold_d;
      rd_pend_q  <= rd_pend_d;
      rd_fwd_q   <= rd_fwd_d;
      rd_oob_q   <= rd_oob_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  pifo_sdp_ram #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_waddr (ram_waddr),
    .i_wdata (ram_wdata),
    .i_re    (ram_re),
    .i_raddr (ram_raddr),
    .o_rdata (ram_rdata)
  );

  assign o_read_data = rd_data;
  assign o_init_done = (state_q == ST_READY);
  assign o_oob       = oob_q;

endmodule

// File: tb/tb_pifo_level_sram.sv
module tb_pifo_level_sram;

  localparam int PTW = 4, MTW = 4, CTW = 3, ADW = 4, DEPTH = 8;
  localparam int EW = 2 * (PTW + MTW + CTW);
  localparam logic [EW-1:0] EMPTY = 22'h00780F;

  logic          clk;
  logic          rst;
  logic          rd;
  logic [ADW-1:0] ra;
  logic [EW-1:0] rdata;
  logic          wr;
  logic [ADW-1:0] wa;
  logic [EW-1:0] wd;
  logic          done;
  logic          oob;

  pifo_level_sram #(
    .PTW(PTW), .MTW(MTW), .CTW(CTW), .ADW(ADW), .DEPTH(DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_read       (rd),
    .i_read_addr  (ra),
    .o_read_data  (rdata),
    .i_write      (wr),
    .i_write_addr (wa),
    .i_write_data (wd),
    .o_init_done  (done),
    .o_oob        (oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: an array of entries, a count of remaining init
  // cycles, the last read result and the sticky oob flag.
  logic [EW-1:0] m_mem [DEPTH];
  int            m_init_left;
  logic [EW-1:0] m_rd;
  logic          m_oob;

  always @(posedge clk) begin
    if (rst) begin
      m_init_left = DEPTH;
      m_rd        = EMPTY;
      m_oob       = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = EMPTY;
    end else if (m_init_left > 0) begin
      m_init_left = m_init_left - 1;
    end else begin
      if (rd) begin
        if (int'(ra) >= DEPTH)                 m_rd = EMPTY;
        else if (wr && wa == ra)               m_rd = wd;
        else                                   m_rd = m_mem[int'(ra)];
      end
      if (wr && int'(wa) < DEPTH) m_mem[int'(wa)] = wd;
      if ((rd && int'(ra) >= DEPTH) || (wr && int'(wa) >= DEPTH)) m_oob = 1'b1;
    end
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle of inputs, wait for the following negedge and compare
  // all outputs against the model.
  task automatic step(input logic r, input logic [ADW-1:0] raddr,
                      input logic w, input logic [ADW-1:0] waddr,
                      input logic [EW-1:0] wdata);
    rd = r; ra = raddr; wr = w; wa = waddr; wd = wdata;
    @(negedge clk);
    chk("model_rdata", rdata, m_rd);
    chk("model_done", EW'(done), EW'(m_init_left == 0));
    chk("model_oob", EW'(oob), EW'(m_oob));
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0);
  endtask

  // Counts low observations of o_init_done after release; init is DEPTH
  // cycles and the first of them is observed before this loop starts.
  task automatic wait_init(input string name);
    int lows;
    lows = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      // try user traffic during init; it must be ignored
      step(1'b1, 4'd5, 1'b1, 4'd3, 22'h3ABCDE);
      chk({name, "_rd_during_init"}, rdata, EMPTY);
      if (!done) lows++;
    end
    chk({name, "_init_lows"}, EW'(lows), EW'(DEPTH - 1));
    chk({name, "_init_done"}, EW'(done), EW'(1));
  endtask

  initial begin
    rst = 1'b1; rd = 0; ra = '0; wr = 0; wa = '0; wd = '0;
    idle(); idle();
    chk("reset_rdata", rdata, EMPTY);
    chk("reset_done", EW'(done), EW'(0));
    chk("reset_oob", EW'(oob), EW'(0));
    rst = 1'b0;
    wait_init("first");

    step(1'b1, 4'd5, 1'b0, '0, '0);
    chk("rd5_empty", rdata, EMPTY);
    // init-time write to addr 3 must have been dropped
    step(1'b1, 4'd3, 1'b0, '0, '0);
    chk("rd3_after_init", rdata, EMPTY);

    step(1'b0, '0, 1'b1, 4'd3, 22'h012345);
    step(1'b1, 4'd3, 1'b0, '0, '0);
    chk("rd3_written", rdata, 22'h012345);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("rd3_hold", rdata, 22'h012345);
    end

    step(1'b1, 4'd2, 1'b1, 4'd2, 22'h00AAAA);
    chk("collide_wf", rdata, 22'h00AAAA);

    step(1'b1, 4'd1, 1'b0, '0, '0);
    chk("rd1_x", rdata, EMPTY);
    step(1'b0, '0, 1'b1, 4'd1, 22'h001111);
    chk("hold_vs_write", rdata, EMPTY);
    step(1'b1, 4'd1, 1'b0, '0, '0);
    chk("rd1_new", rdata, 22'h001111);

    // different addresses in the same cycle are independent
    step(1'b1, 4'd3, 1'b1, 4'd4, 22'h004444);
    chk("indep_rd3", rdata, 22'h012345);
    step(1'b1, 4'd4, 1'b0, '0, '0);
    chk("indep_rd4", rdata, 22'h004444);

    step(1'b0, '0, 1'b1, 4'd9, 22'h3FFFFF);
    chk("oob_set", EW'(oob), EW'(1));
    idle();
    chk("oob_sticky", EW'(oob), EW'(1));
    step(1'b1, 4'd9, 1'b0, '0, '0);
    chk("rd9_empty", rdata, EMPTY);
    step(1'b1, 4'd1, 1'b0, '0, '0);
    chk("rd1_unchanged", rdata, 22'h001111);
    step(1'b1, 4'd7, 1'b0, '0, '0);
    chk("rd7_last_empty", rdata, EMPTY);

    // reset mid-init
    rst = 1'b1; idle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) idle();
    chk("midinit_done_low", EW'(done), EW'(0));
    rst = 1'b1; idle();
    rst = 1'b0;
    wait_init("second");
    step(1'b1, 4'd3, 1'b0, '0, '0);
    chk("rd3_after_reinit", rdata, EMPTY);
    chk("oob_cleared", EW'(oob), EW'(0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
